// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage constants and the fetch FSM state type
package mips_pkg;
  localparam logic [31:0] NOP_INSN  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSN = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP   = 32'd4;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/stage_one_fetch_if_id.sv
// if_id_register: IF/ID pipeline register; clear (to NOP, valid=0) beats hold, otherwise loads with valid=1
// Ports: clk, rst (async, active-high), i_hold, i_clear, i_insn, i_pc -> o_insn, o_pc, o_valid
module if_id_register
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hold,
  input  logic        i_clear,
  input  logic [31:0] i_insn,
  input  logic [31:0] i_pc,
  output logic [31:0] o_insn,
  output logic [31:0] o_pc,
  output logic        o_valid
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_insn  <= NOP_INSN;
      o_pc    <= '0;
      o_valid <= 1'b0;
    end else if (i_clear) begin
      o_insn  <= NOP_INSN;
      o_pc    <= '0;
      o_valid <= 1'b0;
    end else if (!i_hold) begin
      o_insn  <= i_insn;
      o_pc    <= i_pc;
      o_valid <= 1'b1;
    end
endmodule

// File: rtl/stage_one_fetch.sv
// stage_one_fetch: instruction fetch stage (PC, BOOT/RUN/HALT FSM, fetch counter, IF/ID register)
// Ports: clk, reset (async, active-high), stall, flush, branch_taken, branch_target, imem_data
//        -> imem_addr, instruction, pc, valid, fetch_count
// Optional: define STAGE_ONE_HALT_DETECT_EN to stop fetching after HALT_INSN is latched
module stage_one_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        valid,
  output logic [31:0] fetch_count
);
  fetch_state_t r_state, w_state_next;
  logic [31:0] r_pc, r_fetch_count, w_pc_next, w_pc_plus;
  logic        w_run, w_load, w_clear, w_halt_hit;
  logic [1:0]  w_unused_tgt;
  assign w_unused_tgt = branch_target[1:0];
  assign imem_addr    = r_pc;
  assign fetch_count  = r_fetch_count;
  assign w_pc_plus    = r_pc + PC_STEP;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= BOOT;
    else r_state <= w_state_next;
`ifdef STAGE_ONE_HALT_DETECT_EN
  assign w_halt_hit = w_load && (imem_data == HALT_INSN);
`else
  assign w_halt_hit = 1'b0;
`endif
  always_comb begin
    w_state_next = r_state;
    if (r_state == BOOT) w_state_next = RUN;
    else if (r_state == RUN && w_halt_hit) w_state_next = HALT;
  end
  // Outside RUN every control input is ignored and IF/ID is held at NOP.
  always_comb begin
    w_run     = (r_state == RUN);
    w_clear   = !w_run || flush;
    w_load    = w_run && !flush && !stall;
    w_pc_next = !w_run ? r_pc :
                branch_taken ? {branch_target[31:2], 2'b00} :
                stall ? r_pc : w_pc_plus;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_fetch_count <= r_fetch_count + {31'b0, w_load};
    end
  if_id_register u_if_id (
    .clk     (clk),
    .rst     (reset),
    .i_hold  (stall),
    .i_clear (w_clear),
    .i_insn  (imem_data),
    .i_pc    (w_pc_plus),
    .o_insn  (instruction),
    .o_pc    (pc),
    .o_valid (valid)
  );
endmodule

// File: tb/tb_stage_one_fetch.sv
// tb_stage_one_fetch: directed self-checking bench for stage_one_fetch
module tb_stage_one_fetch;
  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken;
  logic [31:0] branch_target, imem_data, imem_addr, instruction, pc, fetch_count;
  logic        valid;
  logic [31:0] imem_addr1, instruction1, pc1, fetch_count1;
  logic        valid1;
  logic [31:0] mem [32];
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;
  always_comb imem_data = (imem_addr < 32'h80) ? mem[imem_addr[6:2]] : 32'hDEAD_BEEF;

  stage_one_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_data(imem_data), .imem_addr(imem_addr),
    .instruction(instruction), .pc(pc), .valid(valid), .fetch_count(fetch_count)
  );

  stage_one_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .flush(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .imem_data(32'h1234_5678), .imem_addr(imem_addr1),
    .instruction(instruction1), .pc(pc1), .valid(valid1), .fetch_count(fetch_count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                         input logic ev, input logic [31:0] ea, input logic [31:0] ec);
    chk({tag, ".instruction"}, instruction, ei);
    chk({tag, ".pc"}, pc, ep);
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, ev});
    chk({tag, ".imem_addr"}, imem_addr, ea);
    chk({tag, ".fetch_count"}, fetch_count, ec);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]  = 32'h2001_0005;
    mem[20] = 32'hFFFF_FFFF;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    #2;
    chk_all("reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("reset.wrap_addr", imem_addr1, 32'hFFFF_FFFC);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_all("boot", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("boot.wrap_addr", imem_addr1, 32'hFFFF_FFFC);
    tick();
    chk_all("fetch0", 32'h2001_0005, 32'h4, 1'b1, 32'h4, 32'h1);
    chk("wrap.pc", pc1, 32'h0);
    chk("wrap.addr", imem_addr1, 32'h0);
    chk("wrap.insn", instruction1, 32'h1234_5678);
    chk("wrap.valid", {31'b0, valid1}, 32'h1);
    tick();
    chk_all("fetch1", 32'h1000_0001, 32'h8, 1'b1, 32'h8, 32'h2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("stall%0d", i), 32'h1000_0001, 32'h8, 1'b1, 32'h8, 32'h2);
    end
    stall = 1'b0;
    tick();
    chk_all("resume", 32'h1000_0002, 32'hC, 1'b1, 32'hC, 32'h3);
    branch_taken = 1'b1; flush = 1'b1; branch_target = 32'h0000_0043;
    tick();
    chk_all("br_flush", 32'h0, 32'h0, 1'b0, 32'h40, 32'h3);
    flush = 1'b0; branch_target = 32'h0000_0008;
    tick();
    chk_all("br_delay", 32'h1000_0010, 32'h44, 1'b1, 32'h8, 32'h4);
    branch_taken = 1'b0; flush = 1'b1;
    tick();
    chk_all("flush", 32'h0, 32'h0, 1'b0, 32'hC, 32'h4);
    flush = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0050;
    tick();
    chk_all("stall_br", 32'h0, 32'h0, 1'b0, 32'h50, 32'h4);
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    chk_all("halt_insn", 32'hFFFF_FFFF, 32'h54, 1'b1, 32'h54, 32'h5);
    tick();
`ifdef STAGE_ONE_HALT_DETECT_EN
    chk_all("halted", 32'h0, 32'h0, 1'b0, 32'h54, 32'h5);
`else
    chk_all("no_halt", 32'h1000_0015, 32'h58, 1'b1, 32'h58, 32'h6);
`endif
    branch_taken = 1'b1; branch_target = 32'h0000_0000;
    tick();
`ifdef STAGE_ONE_HALT_DETECT_EN
    chk_all("halt_ign", 32'h0, 32'h0, 1'b0, 32'h54, 32'h5);
`else
    chk_all("br_run", 32'h1000_0016, 32'h5C, 1'b1, 32'h0, 32'h7);
`endif
    branch_taken = 1'b0; stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("async_rst.wrap_addr", imem_addr1, 32'hFFFF_FFFC);
    #1 reset = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h0000_0040;
    tick();
    chk_all("boot_ign", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    chk_all("refetch", 32'h2001_0005, 32'h4, 1'b1, 32'h4, 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stage_one_fetch.md
STAGE_ONE_FETCH -- requirements
Module: stage_one_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: stall  input  1  hazard stall; holds the PC and the IF/ID register.
REQ-005 Port: flush  input  1  squashes the IF/ID contents to NOP.
REQ-006 Port: branch_taken  input  1  redirects the PC to branch_target.
REQ-007 Port: branch_target  input  32  redirect address.
REQ-008 Port: imem_data  input  32  instruction word, combinational read of imem_addr.
REQ-009 Port: imem_addr  output  32  current fetch PC.
REQ-010 Port: instruction  output  32  registered IF/ID instruction; feeds the decode stage.
REQ-011 Port: pc  output  32  registered PC+4 of the fetched instruction; feeds the decode stage.
REQ-012 Port: valid  output  1  IF/ID register holds a real instruction.
REQ-013 Port: fetch_count  output  32  number of valid instructions latched into IF/ID.

Function
REQ-014 imem_addr SHALL equal the internal PC register pc_q combinationally.
REQ-015 The FSM SHALL have states BOOT, RUN and HALT.
REQ-016 BOOT SHALL last exactly one cycle after reset release, with no fetch, valid=0 and pc_q held, then move to RUN.
REQ-017 In RUN with no stall, flush or branch_taken, each edge SHALL load instruction<=imem_data, pc<=pc_q+4, valid<=1, pc_q<=pc_q+4, and increment fetch_count; fetch latency is 1 cycle.
REQ-018 Priority SHALL be flush > stall for the IF/ID register: flush loads instruction=32'h0, pc=0, valid=0; stall holds IF/ID unchanged.
REQ-019 branch_taken SHALL load pc_q<={branch_target[31:2],2'b00} regardless of stall; with stall=1 and branch_taken=0, pc_q holds.
REQ-020 branch_taken without flush SHALL still latch the current imem_data into IF/ID (the delay slot).
REQ-021 The PC+4 computation SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 fetch_count SHALL increment only on edges where valid is written 1, and SHALL wrap at 2^32.
REQ-023 During BOOT, stall, flush and branch_taken SHALL be ignored.

Reset
REQ-024 Asserting reset at any time, including mid-stall or in HALT, SHALL immediately set pc_q=RESET_PC, instruction=0, pc=0, valid=0, fetch_count=0 and state=BOOT.
REQ-025 Deasserting reset SHALL start BOOT at the next rising edge.

Configuration
REQ-026 Macro STAGE_ONE_HALT_DETECT_EN: when defined, latching imem_data==HALT_INSN in RUN SHALL move the FSM to HALT.
REQ-027 In HALT, pc_q SHALL freeze, the IF/ID register SHALL be NOP with valid=0, fetch_count SHALL freeze, and all inputs except reset SHALL be ignored.
REQ-028 When the macro is undefined, HALT SHALL be unreachable and HALT_INSN SHALL be fetched as an ordinary instruction.

Structure
REQ-029 Shared package mips_pkg SHALL hold: NOP_INSN=32'h0, HALT_INSN=32'hFFFF_FFFF, PC_STEP=4, and the fetch state enum {BOOT, RUN, HALT}.
REQ-030 The IF/ID register (instruction, pc, valid, with hold and clear controls) SHALL be one sub-module named if_id_register; the PC and FSM SHALL stay in the top module.

Verification
REQ-031 Sequential fetch: reset release, imem returns 32'h2001_0005 at address 0 -> after BOOT plus 1 edge, instruction=32'h2001_0005, pc=4, valid=1, imem_addr=4, fetch_count=1.
REQ-032 Stall: stall=1 for 3 cycles at imem_addr=8 -> imem_addr stays 8, IF/ID unchanged, fetch_count unchanged; on release, fetch resumes at 8.
REQ-033 Branch+flush same cycle: branch_taken=1, flush=1, branch_target=32'h0000_0043 -> next cycle imem_addr=32'h40, instruction=0, valid=0.
REQ-034 Wrap: RESET_PC=32'hFFFF_FFFC -> first fetch gives pc=0 and imem_addr=0.
REQ-035 Halt: with macro defined, fetch of 32'hFFFF_FFFF -> state HALT, valid=0 thereafter, imem_addr frozen; with macro undefined, it is latched with valid=1.
REQ-036 Async reset mid-stall: reset pulsed between clock edges -> outputs cleared immediately, imem_addr=RESET_PC.
